// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, byte/strobes/busy out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  // Receiver side: samples rx, produces the byte and strobes.
  modport slave  (input rx, output data, data_valid, frame_err, busy);
  // Line driver / consumer side.
  modport master (output rx, input data, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with internal oversample tick divider.
// Start edge re-phases the divider; bits are sampled once at mid-bit.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk_in,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(8);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  logic          r_rx_meta, r_rx_s;
  logic [TW-1:0] r_tick_cnt;
  state_t        r_state;
  logic [OW-1:0] r_os_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic [7:0]    r_shreg, r_data;
  logic          r_data_valid, r_frame_err;

  logic          w_tick, w_tick_clr;
  state_t        w_state_nxt;
  logic [OW-1:0] w_os_nxt;
  logic [BW-1:0] w_bit_nxt;
  logic [7:0]    w_shreg_nxt, w_data_nxt;
  logic          w_dv_nxt, w_fe_nxt;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Two-flop synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Oversample tick divider, re-zeroed on the start edge to align phase.
  always_ff @(posedge clk_in) begin
    if (rst || w_tick_clr || w_tick) r_tick_cnt <= '0;
    else                             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // FSM, counters, shift register and output strobes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_os_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_os_cnt     <= w_os_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shreg      <= w_shreg_nxt;
      r_data       <= w_data_nxt;
      r_data_valid <= w_dv_nxt;
      r_frame_err  <= w_fe_nxt;
    end
  end

  // Next-state: count ticks within a bit, act only at the decision tick.
  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_dv_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    w_tick_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_os_nxt    = '0;
          w_tick_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_os_cnt == OS_MID) begin
            // Still low at mid start bit: real frame; otherwise a glitch.
            w_os_nxt    = '0;
            w_bit_nxt   = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_os_nxt = r_os_cnt + OW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_shreg_nxt = {r_rx_s, r_shreg[7:1]};
            w_os_nxt    = '0;
            if (r_bit_cnt == BIT_LAST) begin
              w_bit_nxt   = '0;
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + BW'(1);
            end
          end else begin
            w_os_nxt = r_os_cnt + OW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_nxt = '0;
            if (r_rx_s) begin
              // Leaving at mid stop bit gives half a bit to catch a gapless start.
              w_data_nxt  = r_shreg;
              w_dv_nxt    = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_fe_nxt    = 1'b1;
              w_state_nxt = S_WAIT_HIGH;
            end
          end else begin
            w_os_nxt = r_os_cnt + OW'(1);
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not restart frames.
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: serial frames in, observed strobes compared
// against a frame-level expectation queue.
module tb_uart_rx;
  logic clk_in = 1'b0;
  logic rst;
  logic rx0, rx1;
  logic abort;

  always #5 clk_in = ~clk_in;

  uart_rx_if if0();
  uart_rx_if if1();
  assign if0.rx = rx0;
  assign if1.rx = rx1;

  // Fast instance: TICK_DIV = 10, 160 cycles/bit.
  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16))
    u_dut0 (.clk_in(clk_in), .rst(rst), .bus(if0));
  // Non-integer divide instance: true bit 166.67 cycles, TICK_DIV truncates to 10.
  uart_rx #(.CLK_FREQ(100_000_000), .BAUD(600_000), .OVERSAMPLE(16))
    u_dut1 (.clk_in(clk_in), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;

  // Observed events: {1'b0,byte} for data_valid, 9'h100 for frame_err.
  logic [8:0] got0_q[$], got1_q[$], exp0_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst) begin
      if (if0.data_valid) got0_q.push_back({1'b0, if0.data});
      if (if0.frame_err)  got0_q.push_back(9'h100);
      if (if0.data_valid || if0.frame_err)
        chk("strobe_excl0", {31'b0, if0.data_valid & if0.frame_err}, 32'h0);
      if (if1.data_valid) got1_q.push_back({1'b0, if1.data});
      if (if1.frame_err)  got1_q.push_back(9'h100);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic setrx(input int p, input logic v);
    if (p == 0) rx0 = v;
    else        rx1 = v;
  endtask

  // Drive one 8N1 frame (start, 8 data LSB first, stop) at bc cycles/bit.
  task automatic send(input int p, input logic [7:0] b, input logic stopb, input int bc);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (abort) return;
      setrx(p, fr[i]);
      tick(bc);
    end
  endtask

  // Reference: a frame yields its byte if the stop bit is high, else an error.
  task automatic expect_frame(input logic [7:0] b, input logic stopb);
    if (stopb) begin
      exp0_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp0_q.push_back(9'h100);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    tick(5);
    chk({tag, "_count"}, got0_q.size(), exp0_q.size());
    n = (got0_q.size() < exp0_q.size()) ? got0_q.size() : exp0_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_event"}, got0_q[i], exp0_q[i]);
    chk({tag, "_data_hold"}, if0.data, last_good);
    got0_q.delete();
    exp0_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       sb;
    int         gap;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; abort = 1'b0;
    tick(5);
    chk("rst_data", if0.data, 8'h00);
    chk("rst_dv",   if0.data_valid, 1'b0);
    chk("rst_fe",   if0.frame_err, 1'b0);
    chk("rst_busy", if0.busy, 1'b0);
    rst = 1'b0;
    tick(50);

    // 1: single frame after idle, busy covers the frame.
    fork
      send(0, 8'hA5, 1'b1, 160);
      begin
        @(negedge clk_in); chk("t1_busy_pre", if0.busy, 1'b0);
        repeat (6) @(negedge clk_in); chk("t1_busy_start", if0.busy, 1'b1);
        repeat (1400) @(negedge clk_in); chk("t1_busy_mid", if0.busy, 1'b1);
      end
    join
    expect_frame(8'hA5, 1'b1);
    drain("t1");

    // 2: short low glitch rejected at mid start bit, then a real frame.
    rx0 = 1'b0; tick(40);
    chk("t2_busy_hi", if0.busy, 1'b1);
    tick(10); rx0 = 1'b1; tick(90);
    chk("t2_busy_lo", if0.busy, 1'b0);
    drain("t2_glitch");
    send(0, 8'h3C, 1'b1, 160);
    expect_frame(8'h3C, 1'b1);
    drain("t2");
    tick(30);

    // 3: framing error with line held low afterwards.
    send(0, 8'h5A, 1'b0, 160);
    expect_frame(8'h5A, 1'b0);
    tick(340);
    chk("t3_busy_break", if0.busy, 1'b1);
    tick(60); rx0 = 1'b1; tick(10);
    chk("t3_busy_release", if0.busy, 1'b0);
    drain("t3");
    tick(30);

    // 4: back-to-back frames, zero idle gap.
    send(0, 8'h00, 1'b1, 160); expect_frame(8'h00, 1'b1);
    send(0, 8'hFF, 1'b1, 160); expect_frame(8'hFF, 1'b1);
    send(0, 8'h81, 1'b1, 160); expect_frame(8'h81, 1'b1);
    drain("t4");
    tick(30);

    // 5: reset mid bit 4; link goes idle and the frame is dropped.
    fork
      send(0, 8'hC3, 1'b1, 160);
      begin
        tick(880);
        rst = 1'b1; rx0 = 1'b1; abort = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_data", if0.data, 8'h00);
        chk("t5_rst_dv",   if0.data_valid, 1'b0);
        chk("t5_rst_fe",   if0.frame_err, 1'b0);
        chk("t5_rst_busy", if0.busy, 1'b0);
      end
    join
    abort = 1'b0;
    last_good = 8'h00;
    tick(100);
    drain("t5_abort");
    send(0, 8'h42, 1'b1, 160);
    expect_frame(8'h42, 1'b1);
    drain("t5");
    tick(30);

    // Random frames: random bytes, occasional framing errors and gaps.
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 4) != 0);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
      send(0, b, sb, 160);
      expect_frame(b, sb);
      if (!sb) begin
        tick($urandom_range(0, 200));
        rx0 = 1'b1;
        tick(20);
      end
      tick(gap);
    end
    drain("rand");

    // 6: truncated divider tolerance at the true (non-integer) bit period.
    send(1, 8'h55, 1'b1, 167);
    tick(5);
    chk("t6_count", got1_q.size(), 1);
    if (got1_q.size() > 0) chk("t6_event", got1_q[0], 9'h055);
    chk("t6_data", if1.data, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
